neopixel_driver_gen2: RTL and testbench

//  Second-generation WS281x/SK6812 serial driver. Streams a frame from pixel RAM to
//  one NeoPixel line, with parametrised bytes-per-LED (GRB/RGBW), ns-specified timing,

---
 rtl/neopixel_pkg.sv | 14 +
 rtl/neopixel_scale8.sv | 10 +
 rtl/neopixel_driver_gen2.sv | 173 +++++++++++++++++
 tb/tb_neopixel_driver_gen2.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/neopixel_pkg.sv
// neopixel_pkg: shared types, constants and timing helpers for the NeoPixel drivers.
package neopixel_pkg;
    typedef enum logic [2:0] {S_IDLE, S_PREFETCH, S_HI, S_LO, S_RST} state_t;
    localparam int BPP_GRB = 3;
    localparam int BPP_GRBW = 4;
    function automatic int ns2tck(input longint clk_hz, input longint ns);
        longint t;
        t = clk_hz * ns / 64'sd1_000_000_000;
        return (t < 1) ? 1 : int'(t);
    endfunction
    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/neopixel_scale8.sv
// neopixel_scale8: brightness scaling y = (d*(b+1))>>8, so b=255 passes d through.
module neopixel_scale8 (
    input  logic [7:0] d_i,
    input  logic [7:0] b_i,
    output logic [7:0] y_o
);
    logic [15:0] prod_d;
    assign prod_d = {8'd0, d_i} * ({8'd0, b_i} + 16'd1);
    assign y_o = prod_d[15:8];
endmodule

// File: rtl/neopixel_driver_gen2.sv
// neopixel_driver_gen2: streams a frame of pixel RAM bytes onto one WS281x/SK6812 line
// with latched brightness scaling, pipelined RAM reads and frame abort.
module neopixel_driver_gen2
    import neopixel_pkg::*;
#(
    parameter int LEDS = 200,
    parameter int BPP = BPP_GRB,
    parameter int CLK_HZ = 50_000_000,
    parameter int T0H_NS = 350,
    parameter int T0L_NS = 800,
    parameter int T1H_NS = 700,
    parameter int T1L_NS = 600,
    parameter int RST_NS = 80_000,
    parameter int RD_LAT = 1,
    parameter bit REVERSE = 1'b1,
    localparam int NBYTES = LEDS * BPP,
    localparam int AW = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [7:0]    i_brightness,
    output logic          o_busy,
    output logic          o_rd_en,
    output logic [AW-1:0] o_rd_addr,
    input  logic [7:0]    i_rd_data,
    output logic          o_neopixel_out,
    output logic          o_frame_done
);
    localparam int T0H_TCK = ns2tck(CLK_HZ, T0H_NS);
    localparam int T0L_TCK = ns2tck(CLK_HZ, T0L_NS);
    localparam int T1H_TCK = ns2tck(CLK_HZ, T1H_NS);
    localparam int T1L_TCK = ns2tck(CLK_HZ, T1L_NS);
    localparam int RST_TCK = ns2tck(CLK_HZ, RST_NS);
    localparam int MAX_TCK = imax(imax(imax(T0H_TCK, T0L_TCK), imax(T1H_TCK, T1L_TCK)), RST_TCK);
    localparam int CW = $clog2(MAX_TCK + 1);
    localparam int IW = $clog2(NBYTES + 1);

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        bit_q;
    logic [IW-1:0]     byte_q;
    logic [7:0]        sr_q;
    logic [7:0]        next_q;
    logic [7:0]        b_q;
    logic [RD_LAT-1:0] vld_q;
    logic              aborted_q;
    logic [7:0]        scaled_d;
    logic              rd_vld_d;
    logic              last_byte_d;
    logic              more_d;

    function automatic logic [CW-1:0] hi_cnt(input logic b);
        return b ? CW'(T1H_TCK - 1) : CW'(T0H_TCK - 1);
    endfunction

    function automatic logic [CW-1:0] lo_cnt(input logic b);
        return b ? CW'(T1L_TCK - 1) : CW'(T0L_TCK - 1);
    endfunction

    function automatic logic [AW-1:0] addr_of(input int k);
        return AW'(REVERSE ? NBYTES - 1 - k : k);
    endfunction

    neopixel_scale8 u_scale (
        .d_i(i_rd_data),
        .b_i(b_q),
        .y_o(scaled_d)
    );

    assign rd_vld_d = vld_q[RD_LAT-1];
    assign last_byte_d = (byte_q == IW'(NBYTES - 1));
    assign more_d = (32'(byte_q) + 32'd2 < 32'(NBYTES));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            bit_q          <= '0;
            byte_q         <= '0;
            sr_q           <= '0;
            next_q         <= '0;
            b_q            <= '0;
            vld_q          <= '0;
            aborted_q      <= 1'b0;
            o_busy         <= 1'b0;
            o_rd_en        <= 1'b0;
            o_rd_addr      <= '0;
            o_neopixel_out <= 1'b0;
            o_frame_done   <= 1'b0;
        end else begin
            o_rd_en      <= 1'b0;
            o_frame_done <= 1'b0;
            vld_q        <= RD_LAT'({vld_q, o_rd_en});
            case (state_q)
                S_IDLE: if (i_start) begin
                    state_q   <= S_PREFETCH;
                    o_busy    <= 1'b1;
                    b_q       <= i_brightness;
                    byte_q    <= '0;
                    bit_q     <= '0;
                    aborted_q <= 1'b0;
                    o_rd_en   <= 1'b1;
                    o_rd_addr <= addr_of(0);
                end
                S_PREFETCH: if (rd_vld_d) begin
                    state_q        <= S_HI;
                    sr_q           <= scaled_d;
                    cnt_q          <= hi_cnt(scaled_d[7]);
                    o_neopixel_out <= 1'b1;
                    if (NBYTES > 1) begin
                        o_rd_en   <= 1'b1;
                        o_rd_addr <= addr_of(1);
                    end
                end
                S_HI: begin
                    if (rd_vld_d) next_q <= scaled_d;
                    if (cnt_q == '0) begin
                        state_q        <= S_LO;
                        cnt_q          <= lo_cnt(sr_q[7]);
                        o_neopixel_out <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_LO: begin
                    if (rd_vld_d) next_q <= scaled_d;
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else if (bit_q != 3'd7) begin
                        state_q        <= S_HI;
                        bit_q          <= bit_q + 3'd1;
                        sr_q           <= sr_q << 1;
                        cnt_q          <= hi_cnt(sr_q[6]);
                        o_neopixel_out <= 1'b1;
                    end else if (last_byte_d) begin
                        state_q <= S_RST;
                        cnt_q   <= CW'(RST_TCK - 1);
                    end else begin
                        // gapless byte hand-over: the prefetched byte starts on the very next cycle
                        state_q        <= S_HI;
                        bit_q          <= '0;
                        byte_q         <= byte_q + IW'(1);
                        sr_q           <= next_q;
                        cnt_q          <= hi_cnt(next_q[7]);
                        o_neopixel_out <= 1'b1;
                        if (more_d) begin
                            o_rd_en   <= 1'b1;
                            o_rd_addr <= addr_of(int'(byte_q) + 2);
                        end
                    end
                end
                S_RST: if (cnt_q == '0) begin
                    state_q      <= S_IDLE;
                    o_busy       <= 1'b0;
                    o_frame_done <= !aborted_q;
                end else begin
                    cnt_q <= cnt_q - CW'(1);
                end
                default: state_q <= S_IDLE;
            endcase
            if (i_abort && (state_q == S_PREFETCH || state_q == S_HI || state_q == S_LO)) begin
                state_q        <= S_RST;
                cnt_q          <= CW'(RST_TCK - 1);
                o_neopixel_out <= 1'b0;
                o_rd_en        <= 1'b0;
                vld_q          <= '0;
                aborted_q      <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_neopixel_driver_gen2.sv
// tb_neopixel_driver_gen2: randomized frames decoded from the serial line and compared
// against an arithmetic reference of byte order, scaling and bit timing.
module tb_neopixel_driver_gen2;
    import neopixel_pkg::*;
    localparam int LEDS = 2;
    localparam int BPP = BPP_GRBW;
    localparam int RD_LAT = 3;
    localparam bit REVERSE = 1'b1;
    localparam int NB = LEDS * BPP;
    localparam int AW = $clog2(NB);
    localparam int MHZ = 50;
    localparam int T0H = MHZ * 350 / 1000;
    localparam int T0L = MHZ * 800 / 1000;
    localparam int T1H = MHZ * 700 / 1000;
    localparam int T1L = MHZ * 600 / 1000;
    localparam int RST = MHZ * 4000 / 1000;

    logic clk = 1'b0;
    logic i_rst_n, i_start, i_abort;
    logic [7:0] i_brightness, i_rd_data, junk;
    logic o_busy, o_rd_en, o_neopixel_out, o_frame_done;
    logic [AW-1:0] o_rd_addr;
    logic [7:0] mem [NB];
    logic [7:0] dpipe [RD_LAT];
    logic [RD_LAT-1:0] vpipe = '0;
    int checks = 0, errors = 0;
    logic line_q[$];
    logic [AW-1:0] addr_q[$];
    int done_cnt, abort_idx;

    always #5 clk = ~clk;

    neopixel_driver_gen2 #(
        .LEDS(LEDS), .BPP(BPP), .CLK_HZ(MHZ * 1_000_000), .T0H_NS(350), .T0L_NS(800),
        .T1H_NS(700), .T1L_NS(600), .RST_NS(4000), .RD_LAT(RD_LAT), .REVERSE(REVERSE)
    ) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
        .i_brightness(i_brightness), .o_busy(o_busy), .o_rd_en(o_rd_en),
        .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data), .o_neopixel_out(o_neopixel_out),
        .o_frame_done(o_frame_done)
    );

    // RAM model: data is only meaningful exactly RD_LAT cycles after a strobe, junk otherwise
    always @(posedge clk) begin
        dpipe[0] <= mem[o_rd_addr];
        for (int i = 1; i < RD_LAT; i++) dpipe[i] <= dpipe[i-1];
        vpipe <= {vpipe[RD_LAT-2:0], o_rd_en};
        junk <= 8'($urandom);
    end
    assign i_rd_data = vpipe[RD_LAT-1] ? dpipe[RD_LAT-1] : junk;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ref_addr(input int k);
        return REVERSE ? NB - 1 - k : k;
    endfunction

    function automatic logic [7:0] scale_ref(input logic [7:0] d, input logic [7:0] b);
        return 8'((int'(d) * (int'(b) + 1)) / 256);
    endfunction

    task automatic fill_random();
        for (int i = 0; i < NB; i++) mem[i] = 8'($urandom);
    endtask

    task automatic run_frame(input logic [7:0] b, input int abort_rise, input int restart_cyc, input int rst_cyc);
        int cyc = 0, rises = 0;
        logic prev = 1'b0;
        line_q.delete();
        addr_q.delete();
        done_cnt = 0;
        abort_idx = -1;
        i_brightness = b;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_brightness = 8'($urandom);
        chk("busy_rise", o_busy, 1);
        while (o_busy && cyc < 20000) begin
            line_q.push_back(o_neopixel_out);
            if (o_rd_en) addr_q.push_back(o_rd_addr);
            done_cnt += int'(o_frame_done);
            rises += int'(o_neopixel_out && !prev);
            prev = o_neopixel_out;
            i_abort = (abort_rise != 0 && rises == abort_rise && abort_idx < 0);
            if (i_abort) abort_idx = cyc;
            i_start = (cyc == restart_cyc);
            i_rst_n = !(cyc == rst_cyc);
            @(negedge clk);
            cyc++;
        end
        i_abort = 1'b0;
        i_start = 1'b0;
        i_rst_n = 1'b1;
        chk("frame_timeout", longint'(cyc < 20000), 1);
    endtask

    task automatic check_frame(input logic [7:0] b);
        int i = 0, first, hi, lo, badw = 0, total = 0;
        logic [7:0] e, got;
        chk("done_end", o_frame_done, 1);
        chk("done_early", done_cnt, 0);
        chk("n_reads", addr_q.size(), NB);
        while (i < line_q.size() && !line_q[i]) i++;
        first = i;
        for (int k = 0; k < NB; k++) begin
            e = scale_ref(mem[ref_addr(k)], b);
            got = '0;
            if (k < addr_q.size()) chk($sformatf("addr%0d", k), addr_q[k], ref_addr(k));
            for (int j = 7; j >= 0; j--) begin
                hi = 0;
                lo = 0;
                while (i < line_q.size() && line_q[i]) begin hi++; i++; end
                while (i < line_q.size() && !line_q[i]) begin lo++; i++; end
                got[j] = (hi == T1H);
                total += e[j] ? T1H + T1L : T0H + T0L;
                badw += int'(hi != (e[j] ? T1H : T0H));
                badw += int'(lo != (e[j] ? T1L : T0L) + ((k == NB - 1 && j == 0) ? RST : 0));
            end
            chk($sformatf("byte%0d", k), got, e);
        end
        chk("widths", badw, 0);
        chk("frame_len", line_q.size() - first, total + RST);
        @(negedge clk);
        chk("done_pulse", o_frame_done, 0);
    endtask

    initial begin
        int n;
        logic [7:0] b;
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_abort = 1'b0;
        i_brightness = '0;
        fill_random();
        repeat (3) @(negedge clk);
        chk("rst_out", {o_busy, o_rd_en, o_neopixel_out, o_frame_done, o_rd_addr}, 0);
        i_rst_n = 1'b1;
        @(negedge clk);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        chk("idle_abort", {o_busy, o_neopixel_out}, 0);

        mem[ref_addr(0)] = 8'hA5;
        mem[ref_addr(1)] = 8'h00;
        mem[ref_addr(2)] = 8'hFF;
        run_frame(8'hFF, 0, -1, -1);
        check_frame(8'hFF);

        for (int i = 0; i < NB; i++) mem[i] = 8'hFF;
        run_frame(8'd127, 0, -1, -1);
        check_frame(8'd127);

        i_abort = 1'b1;
        run_frame(8'd0, 0, -1, -1);
        check_frame(8'd0);

        fill_random();
        b = 8'($urandom);
        run_frame(b, 0, 100, -1);
        check_frame(b);
        n = 0;
        repeat (30) begin
            @(negedge clk);
            n += int'(o_busy) + int'(o_rd_en);
        end
        chk("no_restart", n, 0);

        fill_random();
        run_frame(8'($urandom), 19, -1, -1);
        chk("abort_seen", longint'(abort_idx >= 0), 1);
        chk("abort_line", (abort_idx >= 0 && abort_idx + 1 < line_q.size()) ? line_q[abort_idx+1] : 1'b1, 0);
        chk("abort_rst_len", line_q.size() - 1 - abort_idx, RST);
        n = 0;
        for (int i = abort_idx + 1; i < line_q.size(); i++) n += int'(line_q[i]);
        chk("abort_hi", n, 0);
        chk("abort_done", done_cnt + int'(o_frame_done), 0);

        fill_random();
        run_frame(8'($urandom), 0, -1, 500);
        chk("midrst_out", {o_busy, o_rd_en, o_neopixel_out, o_frame_done, o_rd_addr}, 0);
        chk("midrst_len", line_q.size(), 501);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            n += int'(o_busy) + int'(o_frame_done);
        end
        chk("midrst_idle", n, 0);

        fill_random();
        b = 8'($urandom);
        run_frame(b, 0, -1, -1);
        check_frame(b);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
